bf16_dotprod_acc: RTL
=====================

Name: bf16_dotprod_acc

Overview:
- Parametrised, fully pipelined bfloat16 dot-product engine: VEC_LEN parallel multipliers, a registered pairwise adder tree and an output accumulator.
- Successor to the fixed 10-element dot product, which stops after the multiply layer.
- Adds a completed reduction tree, valid/ready handshakes with backpressure, and multi-beat accumulation so vectors longer than VEC_LEN stream in as chunks.
- Built from the existing combinational bfloat16_mult and bfloat16_adder cells.

Parameters:
- VEC_LEN, 8, elements per input beat; any value >= 2; the tree is padded to the next power of two (P2).
- CNT_W, 8, width of the chunk counter output.
- TREE_LVLS, $clog2(VEC_LEN), derived and not overridable: number of adder-tree levels.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat this cycle.
- in_last  in  1  beat is the final chunk of the current dot product.
- horz  in  [0:VEC_LEN*16-1]  vector A; element i occupies bits i*16 .. i*16+15.
- vert  in  [0:VEC_LEN*16-1]  vector B, same packing as horz.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer accepts the result.
- out  out  [0:15]  bfloat16 dot-product result.
- out_chunks  out  CNT_W  number of beats summed into out; saturates at 2^CNT_W-1.

Behaviour:
- Stage pipeline:
  - S0: input register.
  - S1: products registered.
  - S2 .. S(1+TREE_LVLS): one registered adder-tree level each.
  - Final stage: accumulator / output register.
- Each stage carries a valid bit and a last tag.
- Latency: an accepted beat with in_last=1 produces out_valid exactly 3+TREE_LVLS cycles later when there is no stall (VEC_LEN=4 gives 5 cycles).
- Global stall: adv = !(out_valid && !out_ready).
  - in_ready = adv; this is combinational from out_ready.
  - When adv=0, every stage register, the accumulator and the counter hold.
  - A beat is accepted only when in_valid && in_ready.
- Tree order is fixed for bit-exactness:
  - Level 0 adds pairs (2k, 2k+1); each higher level does the same on the previous level's results.
  - Padding lanes hold product 16'h0000.
- Accumulator, on a valid tree result while adv=1:
  - first = !acc_active; sum = first ? tree : bfloat16_adder(acc, tree).
  - last=0: acc <= sum; acc_active <= 1; cnt <= sat(cnt+1).
  - last=1: out <= sum; out_chunks <= sat(cnt+1); out_valid <= 1; acc_active <= 0; cnt <= 0.
- out_valid clears on out_valid && out_ready unless a new last result loads the same cycle, in which case it stays 1 with the new data. Full throughput is one beat per clock.
- Reset:
  - Clears all stage valids, acc_active and cnt.
  - out_valid=0, out=16'h0000, out_chunks=0.
  - Datapath registers other than out are not reset.
  - Reset mid-accumulation discards the partial sum and all in-flight beats; the first beat after reset starts a fresh product.
- Arithmetic (rounding, denormals, NaN/Inf) is exactly that of the shared bfloat16_mult and bfloat16_adder cells; this block adds no rounding of its own.

Optional Feature:
- DOTPROD_DEBUG_EN defined:
  - Adds output port mult_out_r [0:VEC_LEN*16-1], a direct view of the S1 product register.
  - It is not reset and it follows the stall.
- Undefined: the port and its fan-out are absent. Behaviour and latency are identical either way.

Decomposition:
- Package bf16_pkg: BF16_W=16, BF16_ZERO=16'h0000, BF16_ONE=16'h3F80, and a clog2 helper function.
- One sub-module, bf16_add_tree:
  - Parameters N and P2; N products in, one sum out; one register per level.
  - Takes the shared advance enable and carries the valid/last tags alongside the data.
- Top level holds the input/multiply stages, the accumulator FSM (IDLE = !acc_active, ACCUM = acc_active), the counter and the handshake.

Test Plan:
- VEC_LEN=4; horz all 3F80, vert all 4000, last=1, out_ready=1 -> out=4100 (8.0) and out_chunks=1, exactly 5 cycles after acceptance.
- Two beats of the above back-to-back, last on the second -> a single output out=4180 (16.0), out_chunks=2; no output after the first beat.
- out_ready held 0, 4 consecutive last-beats with distinct expected sums -> in_ready drops once out_valid=1; after out_ready=1, all 4 results emerge in order with none lost or duplicated.
- One non-last beat (sum 8.0), rst for 1 cycle, then a last beat of 1.0*1.0 x4 -> out=4080 (4.0), not 4180; out_chunks=1.
- VEC_LEN=3; horz {3F80,4000,4040}, vert all 3F80 -> out=40C0 (6.0), confirming padding.
- Compile with DOTPROD_DEBUG_EN; horz all 4000, vert all 4000 -> mult_out_r shows 4080 in every lane one cycle after acceptance.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants and an elaboration-time log2 helper for the
// dot-product engine and its arithmetic cells.
package bf16_pkg;
   localparam int          BF16_W    = 16;
   localparam logic [15:0] BF16_ZERO = 16'h0000;
   localparam logic [15:0] BF16_ONE  = 16'h3F80;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction
endpackage

// File: rtl/bf16_add_tree.sv
// Registered pairwise bfloat16 reduction tree (heap-ordered, one register per level)
// with valid/last tags travelling alongside; all registers advance on en.
module bf16_add_tree
   import bf16_pkg::*;
#(
   parameter int N  = 8,
   parameter int P2 = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                in_vld,
   input  logic                in_last,
   input  logic [0:N*BF16_W-1] in_data,
   output logic                out_vld,
   output logic                out_last,
   output logic [BF16_W-1:0]   out_sum
);
   localparam int LVLS = clog2(P2);

   logic [BF16_W-1:0] leaf   [P2];
   logic [BF16_W-1:0] node_y [1:P2-1];
   logic [BF16_W-1:0] node_d [1:P2-1];
   logic [BF16_W-1:0] node_q [1:P2-1];
   logic [LVLS-1:0]   vld_d, vld_q, last_d, last_q;

   for (genvar j = 0; j < P2; j++) begin : g_leaf
      if (j < N) begin : g_real
         assign leaf[j] = in_data[j*BF16_W +: BF16_W];
      end else begin : g_pad
         assign leaf[j] = BF16_ZERO;
      end
   end

   // node i sums children 2i and 2i+1; nodes whose children are leaves form the first level
   for (genvar i = 1; i < P2; i++) begin : g_node
      if (2*i >= P2) begin : g_first
         bfloat16_adder u_add (.a(leaf[2*i-P2]), .b(leaf[2*i+1-P2]), .y(node_y[i]));
      end else begin : g_upper
         bfloat16_adder u_add (.a(node_q[2*i]), .b(node_q[2*i+1]), .y(node_y[i]));
      end
   end

   always_comb begin
      for (int i = 1; i < P2; i++) node_d[i] = en ? node_y[i] : node_q[i];
      vld_d  = en ? LVLS'({vld_q, in_vld})   : vld_q;
      last_d = en ? LVLS'({last_q, in_last}) : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   always_ff @(posedge clk) begin
      node_q <= node_d;
      last_q <= last_d;
   end

   assign out_vld  = vld_q[LVLS-1];
   assign out_last = last_q[LVLS-1];
   assign out_sum  = node_q[1];
endmodule

// File: rtl/bfloat16_adder.sv
// Combinational bfloat16 adder: denormals flush to zero, guard/round/sticky with
// round to nearest even, canonical NaN 16'h7FC0.
module bfloat16_adder
   import bf16_pkg::*;
(
   input  logic [BF16_W-1:0] a,
   input  logic [BF16_W-1:0] b,
   output logic [BF16_W-1:0] y
);
   logic [BF16_W-1:0] fa, fb, big, sml;
   logic [11:0]       mb, ms, sum;
   logic [7:0]        shamt;
   logic [8:0]        mant;
   logic signed [9:0] exp;
   logic              sticky, rnd, a_inf, b_inf, a_nan, b_nan;

   always_comb begin
      fa    = (a[14:7] == 8'h00) ? {a[15], 15'h0000} : a;
      fb    = (b[14:7] == 8'h00) ? {b[15], 15'h0000} : b;
      a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      if (fa[14:0] >= fb[14:0]) begin
         big = fa;
         sml = fb;
      end else begin
         big = fb;
         sml = fa;
      end
      // bit 11 carry, [10:3] mantissa with hidden bit, [2:0] guard/round/sticky
      mb     = {1'b0, big[14:7] != 8'h00, big[6:0], 3'b000};
      ms     = {1'b0, sml[14:7] != 8'h00, sml[6:0], 3'b000};
      shamt  = big[14:7] - sml[14:7];
      sticky = 1'b0;
      for (int i = 0; i < 12; i++)
         if (i < int'(shamt)) sticky = sticky | ms[i];
      ms    = (shamt > 8'd11) ? 12'h000 : (ms >> shamt);
      ms[0] = ms[0] | sticky;
      exp   = $signed({2'b00, big[14:7]});
      if (big[15] == sml[15]) begin
         sum = mb + ms;
         if (sum[11]) begin
            sum = {1'b0, sum[11:2], sum[1] | sum[0]};
            exp = exp + 10'sd1;
         end
      end else begin
         sum = mb - ms;
         for (int i = 0; i < 11; i++)
            if (!sum[10] && (sum != 12'h000)) begin
               sum = sum << 1;
               exp = exp - 10'sd1;
            end
      end
      rnd  = sum[2] && (sum[1] || sum[0] || sum[3]);
      mant = {1'b0, sum[10:3]} + {8'h00, rnd};
      if (mant[8]) begin
         mant = {1'b0, mant[8:1]};
         exp  = exp + 10'sd1;
      end
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) y = 16'h7FC0;
      else if (a_inf)               y = a;
      else if (b_inf)               y = b;
      else if (sum == 12'h000)      y = BF16_ZERO;
      else if (exp <= 10'sd0)       y = {big[15], 15'h0000};
      else if (exp >= 10'sd255)     y = {big[15], 8'hFF, 7'h00};
      else                          y = {big[15], exp[7:0], mant[6:0]};
   end
endmodule

// File: rtl/bfloat16_mult.sv
// Combinational bfloat16 multiplier: denormals flush to zero, round to nearest even,
// canonical NaN 16'h7FC0.
module bfloat16_mult
   import bf16_pkg::*;
(
   input  logic [BF16_W-1:0] a,
   input  logic [BF16_W-1:0] b,
   output logic [BF16_W-1:0] y
);
   logic              sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rnd;
   logic [15:0]       mprod, norm;
   logic [7:0]        mant;
   logic signed [9:0] exp;

   always_comb begin
      sgn    = a[15] ^ b[15];
      a_zero = (a[14:7] == 8'h00);
      b_zero = (b[14:7] == 8'h00);
      a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      mprod  = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
      exp    = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;
      norm   = mprod;
      if (mprod[15]) exp = exp + 10'sd1;
      else           norm = mprod << 1;
      rnd  = norm[7] && ((|norm[6:0]) || norm[8]);
      mant = {1'b0, norm[14:8]} + {7'h00, rnd};
      if (mant[7]) exp = exp + 10'sd1;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y = 16'h7FC0;
      else if (a_inf || b_inf)     y = {sgn, 8'hFF, 7'h00};
      else if (a_zero || b_zero)   y = {sgn, 15'h0000};
      else if (exp >= 10'sd255)    y = {sgn, 8'hFF, 7'h00};
      else if (exp <= 10'sd0)      y = {sgn, 15'h0000};
      else                         y = {sgn, exp[7:0], mant[6:0]};
   end
endmodule

// File: rtl/bf16_dotprod_acc.sv
// Pipelined bfloat16 dot product with multi-beat accumulation and valid/ready backpressure.
// Define DOTPROD_DEBUG_EN to expose the product register on mult_out_r.
module bf16_dotprod_acc
   import bf16_pkg::*;
#(
   parameter int VEC_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic [0:VEC_LEN*BF16_W-1] horz,
   input  logic [0:VEC_LEN*BF16_W-1] vert,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [0:BF16_W-1]         out,
   output logic [CNT_W-1:0]          out_chunks
`ifdef DOTPROD_DEBUG_EN
   ,
   output logic [0:VEC_LEN*BF16_W-1] mult_out_r
`endif
);
   localparam int TREE_LVLS = clog2(VEC_LEN);
   localparam int P2        = 1 << TREE_LVLS;

   typedef enum logic {IDLE, ACCUM} acc_state_e;

   logic                      adv;
   logic                      vld_p0_d, vld_p0_q, last_p0_d, last_p0_q;
   logic                      vld_p1_d, vld_p1_q, last_p1_d, last_p1_q;
   logic [0:VEC_LEN*BF16_W-1] horz_p0_d, horz_p0_q, vert_p0_d, vert_p0_q;
   logic [0:VEC_LEN*BF16_W-1] prod_w, prod_p1_d, prod_p1_q;
   logic                      t_vld, t_last;
   logic [BF16_W-1:0]         t_sum, acc_add, sum_w;
   acc_state_e                state_d, state_q;
   logic [BF16_W-1:0]         acc_d, acc_q, out_d, out_q;
   logic [CNT_W-1:0]          cnt_d, cnt_q, chunks_d, chunks_q;
   logic                      out_valid_d, out_valid_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign adv      = !(out_valid_q && !out_ready);
   assign in_ready = adv;

   // S0 -> S1: one multiplier per lane
   for (genvar i = 0; i < VEC_LEN; i++) begin : g_mul
      bfloat16_mult u_mul (
         .a(horz_p0_q[i*BF16_W +: BF16_W]),
         .b(vert_p0_q[i*BF16_W +: BF16_W]),
         .y(prod_w[i*BF16_W +: BF16_W])
      );
   end

   // S1 -> S(1+TREE_LVLS): reduction tree
   bf16_add_tree #(.N(VEC_LEN), .P2(P2)) u_tree (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .in_vld  (vld_p1_q),
      .in_last (last_p1_q),
      .in_data (prod_p1_q),
      .out_vld (t_vld),
      .out_last(t_last),
      .out_sum (t_sum)
   );

   bfloat16_adder u_acc_add (.a(acc_q), .b(t_sum), .y(acc_add));
   assign sum_w = (state_q == ACCUM) ? acc_add : t_sum;

   always_comb begin
      vld_p0_d    = adv ? in_valid  : vld_p0_q;
      last_p0_d   = adv ? in_last   : last_p0_q;
      horz_p0_d   = adv ? horz      : horz_p0_q;
      vert_p0_d   = adv ? vert      : vert_p0_q;
      vld_p1_d    = adv ? vld_p0_q  : vld_p1_q;
      last_p1_d   = adv ? last_p0_q : last_p1_q;
      prod_p1_d   = adv ? prod_w    : prod_p1_q;
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      chunks_d    = chunks_q;
      out_valid_d = out_valid_q;
      // final stage: a held result only drains when adv, so it clears unless replaced
      if (adv) begin
         out_valid_d = 1'b0;
         if (t_vld) begin
            if (t_last) begin
               out_d       = sum_w;
               chunks_d    = sat_inc(cnt_q);
               out_valid_d = 1'b1;
               state_d     = IDLE;
               cnt_d       = '0;
            end else begin
               acc_d   = sum_w;
               state_d = ACCUM;
               cnt_d   = sat_inc(cnt_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0_q    <= 1'b0;
         vld_p1_q    <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_q       <= BF16_ZERO;
         chunks_q    <= '0;
      end else begin
         vld_p0_q    <= vld_p0_d;
         vld_p1_q    <= vld_p1_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         chunks_q    <= chunks_d;
      end
   end

   always_ff @(posedge clk) begin
      last_p0_q <= last_p0_d;
      horz_p0_q <= horz_p0_d;
      vert_p0_q <= vert_p0_d;
      last_p1_q <= last_p1_d;
      prod_p1_q <= prod_p1_d;
      acc_q     <= acc_d;
   end

   assign out_valid  = out_valid_q;
   assign out        = out_q;
   assign out_chunks = chunks_q;
`ifdef DOTPROD_DEBUG_EN
   assign mult_out_r = prod_p1_q;
`endif
endmodule
